// File: rtl/hilo_muldiv.sv
// HI/LO register unit: one-cycle multiply capture, 32-step restoring divider,
// and MTHI/MTLO writes. busy is a decode of the registered state.
module hilo_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_mul,
    input  logic                 start_div,
    input  logic                 ifunsigned,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [2*WIDTH-1:0]   alu_result,
    input  logic                 mthi,
    input  logic                 mtlo,
    input  logic [WIDTH-1:0]     wdata,
    output logic [WIDTH-1:0]     hi_out,
    output logic [WIDTH-1:0]     lo_out,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_FIX
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] bmag_q, bmag_d;
    logic [WIDTH-1:0] aorig_q, aorig_d;
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] rem_sub;
    logic             rem_ge;

    // Two's-complement negation keeps the most negative value as-is, so its
    // magnitude is still correct when read as unsigned.
    assign a_neg = A[WIDTH-1] & ~ifunsigned;
    assign b_neg = B[WIDTH-1] & ~ifunsigned;
    assign a_mag = a_neg ? -A : A;
    assign b_mag = b_neg ? -B : B;

    assign rem_sh  = {rem_q, quo_q[WIDTH-1]};
    assign rem_ge  = rem_sh >= {1'b0, bmag_q};
    assign rem_sub = rem_sh[WIDTH-1:0] - bmag_q;

    always_comb begin
        // NOTE: every next-state value defaults to its register first, so no
        // path through the case statement can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        bmag_d  = bmag_q;
        aorig_d = aorig_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_div) begin
                    sa_d    = a_neg;
                    sb_d    = b_neg;
                    quo_d   = a_mag;
                    bmag_d  = b_mag;
                    aorig_d = A;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = S_DIV;
                end else if (start_mul) begin
                    hi_d   = alu_result[2*WIDTH-1:WIDTH];
                    lo_d   = alu_result[WIDTH-1:0];
                    done_d = 1'b1;
                end else begin
                    if (mthi) hi_d = wdata;
                    if (mtlo) lo_d = wdata;
                end
            end

            S_DIV: begin
                // quo_q doubles as the dividend shift register; quotient bits
                // enter at the bottom as dividend bits leave the top.
                rem_d = rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], rem_ge};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_STEP) state_d = S_FIX;
            end

            S_FIX: begin
                if (bmag_q == '0) begin
                    hi_d = aorig_q;
                    lo_d = '1;
                end else begin
                    lo_d = (sa_q ^ sb_q) ? -quo_q : quo_q;
                    hi_d = sa_q ? -rem_q : rem_q;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments only, so every
    // flop samples the pre-edge value of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            bmag_q  <= '0;
            aorig_q <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            bmag_q  <= bmag_d;
            aorig_q <= aorig_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign hi_out = hi_q;
    assign lo_out = lo_q;
    assign busy   = (state_q != S_IDLE);
    assign done   = done_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Scoreboard bench for hilo_muldiv: stimulus pushes expected {HI,LO} into a
// queue, and a negedge monitor pops and compares whenever done is high.
module tb_hilo_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_mul, start_div, ifunsigned;
    logic [31:0] A, B;
    logic [63:0] alu_result;
    logic        mthi, mtlo;
    logic [31:0] wdata;
    logic [31:0] hi_out, lo_out;
    logic        busy, done;

    int          total = 0;
    int          bad   = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_exp;
    logic [31:0] model_hi, model_lo;

    always #5 clk = ~clk;

    hilo_muldiv #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_mul  (start_mul),
        .start_div  (start_div),
        .ifunsigned (ifunsigned),
        .A          (A),
        .B          (B),
        .alu_result (alu_result),
        .mthi       (mthi),
        .mtlo       (mtlo),
        .wdata      (wdata),
        .hi_out     (hi_out),
        .lo_out     (lo_out),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'(done), 64'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("result_hilo", {hi_out, lo_out}, mon_exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic uns,
                           input logic [31:0] ehi, input logic [31:0] elo, input logic combo);
        int cycles;
        A          = a;
        B          = b;
        ifunsigned = uns;
        start_div  = 1'b1;
        if (combo) begin
            start_mul  = 1'b1;
            alu_result = 64'hDEADBEEF_01234567;
            mtlo       = 1'b1;
            wdata      = 32'h11111111;
        end
        exp_q.push_back({ehi, elo});
        tick();
        start_div  = 1'b0;
        start_mul  = 1'b0;
        mtlo       = 1'b0;
        A          = 32'hFFFFFFFF;
        B          = 32'h00000000;
        ifunsigned = ~uns;
        check("accept_busy", 64'(busy), 64'd1);
        check("accept_hilo_held", {hi_out, lo_out}, {model_hi, model_lo});
        cycles = 0;
        while (busy === 1'b1 && cycles < 100) begin
            if (cycles == 5) begin
                mthi      = 1'b1;
                mtlo      = 1'b1;
                start_mul = 1'b1;
                wdata     = 32'h0BAD0BAD;
            end
            tick();
            cycles++;
            if (cycles == 6) begin
                mthi      = 1'b0;
                mtlo      = 1'b0;
                start_mul = 1'b0;
                check("busy_hilo_held", {hi_out, lo_out}, {model_hi, model_lo});
            end
        end
        check("busy_cycles", 64'(cycles), 64'd33);
        check("done_at_fix", 64'(done), 64'd1);
        model_hi = ehi;
        model_lo = elo;
        tick();
        check("done_one_cycle", 64'(done), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        start_mul  = 1'b0;
        start_div  = 1'b0;
        ifunsigned = 1'b0;
        A          = '0;
        B          = '0;
        alu_result = '0;
        mthi       = 1'b0;
        mtlo       = 1'b0;
        wdata      = '0;
        model_hi   = '0;
        model_lo   = '0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_hilo", {hi_out, lo_out}, 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);

        // Multiply capture, latency 1
        alu_result = 64'h00000003_FFFFFFFE;
        start_mul  = 1'b1;
        exp_q.push_back(64'h00000003_FFFFFFFE);
        tick();
        start_mul = 1'b0;
        check("mul_busy", 64'(busy), 64'd0);
        check("mul_done", 64'(done), 64'd1);
        model_hi = 32'h00000003;
        model_lo = 32'hFFFFFFFE;
        tick();
        check("mul_done_one_cycle", 64'(done), 64'd0);

        // Divisions: a, b, unsigned, HI (remainder), LO (quotient)
        run_div(32'd100,        32'd7,        1'b1, 32'd2,        32'd14,       1'b0);
        run_div(32'hFFFFFFF9,   32'd2,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run_div(32'hFFFFFFF9,   32'd2,        1'b1, 32'd1,        32'h7FFFFFFC, 1'b0);
        run_div(32'd7,          32'hFFFFFFFE, 1'b0, 32'd1,        32'hFFFFFFFD, 1'b0);
        run_div(32'h80000000,   32'hFFFFFFFF, 1'b0, 32'd0,        32'h80000000, 1'b0);
        run_div(32'd5,          32'd0,        1'b0, 32'd5,        32'hFFFFFFFF, 1'b0);
        run_div(32'hFFFFFFF9,   32'd0,        1'b0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b0);

        // Reset 10 cycles into a division aborts it with no done pulse
        A          = 32'd1000;
        B          = 32'd3;
        ifunsigned = 1'b1;
        start_div  = 1'b1;
        tick();
        start_div = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hilo", {hi_out, lo_out}, 64'd0);
        check("abort_done", 64'(done), 64'd0);
        model_hi = '0;
        model_lo = '0;
        run_div(32'd9, 32'd3, 1'b0, 32'd0, 32'd3, 1'b0);

        // start_div + start_mul + mtlo together: only the division runs
        run_div(32'd23, 32'd5, 1'b1, 32'd3, 32'd4, 1'b1);

        // mthi + mtlo together
        wdata = 32'hCAFEBABE;
        mthi  = 1'b1;
        mtlo  = 1'b1;
        tick();
        mthi = 1'b0;
        mtlo = 1'b0;
        check("mthilo_hilo", {hi_out, lo_out}, 64'hCAFEBABE_CAFEBABE);
        check("mthilo_done", 64'(done), 64'd0);

        // mtlo alone leaves HI untouched
        wdata = 32'h12345678;
        mtlo  = 1'b1;
        tick();
        mtlo = 1'b0;
        check("mtlo_hilo", {hi_out, lo_out}, 64'hCAFEBABE_12345678);

        // start_mul outranks mthi in the same cycle
        alu_result = 64'h00000001_00000002;
        start_mul  = 1'b1;
        mthi       = 1'b1;
        wdata      = 32'h55555555;
        exp_q.push_back(64'h00000001_00000002);
        tick();
        start_mul = 1'b0;
        mthi      = 1'b0;
        check("mul_over_mthi_done", 64'(done), 64'd1);
        tick();
        check("mul_over_mthi_hi", 64'(hi_out), 64'h00000001);

        tick();
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
